// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: FSM states, ALU opcodes
// and the instruction field layout.
package alu_seq_pkg;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

  localparam logic [1:0] kAND = 2'd0;
  localparam logic [1:0] kADD = 2'd1;
  localparam logic [1:0] kXOR = 2'd2;
  localparam logic [1:0] kSUB = 2'd3;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 9;

  localparam int IMM_BIT = 8;
  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int RD_HI   = 5;
  localparam int RD_LO   = 4;
  localparam int RS_HI   = 3;
  localparam int RS_LO   = 2;
  localparam int IMM4_HI = 3;
  localparam int IMM4_LO = 0;

  typedef struct packed {
    logic       imm;
    logic [1:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [3:0] imm4;
  } instr_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] ins);
    instr_t d;
    d.imm  = ins[IMM_BIT];
    d.op   = ins[OP_HI:OP_LO];
    d.rd   = ins[RD_HI:RD_LO];
    d.rs   = ins[RS_HI:RS_LO];
    d.imm4 = ins[IMM4_HI:IMM4_LO];
    return d;
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 4x8 register file: two operand read ports, one inspection read port and a
// single write port shared between preload and write-back.
module seq_regfile
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [1:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              wb_en,
  input  logic [1:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        rd_a_addr,
  input  logic [1:0]        rd_b_addr,
  input  logic [1:0]        rd_c_addr,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [DATA_W-1:0] rd_c_data
);

  logic [3:0][DATA_W-1:0] regs_q, regs_d;

  // load_en and wb_en come from different FSM states, so they never overlap
  always_comb begin
    regs_d = regs_q;
    if (wb_en)        regs_d[wb_addr]   = wb_data;
    else if (load_en) regs_d[load_addr] = load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign rd_a_data = regs_q[rd_a_addr];
  assign rd_b_data = regs_q[rd_b_addr];
  assign rd_c_data = regs_q[rd_c_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer feeding an external ALU: latch, read
// operands, capture Result, write back and update the zero flag.
module alu_sequencer
  import alu_seq_pkg::*;
(
  input  logic               CLK,
  input  logic               Reset,
  input  logic               InstrValid,
  input  logic [INSTR_W-1:0] Instr,
  output logic               InstrReady,
  input  logic               LoadEn,
  input  logic [1:0]         LoadAddr,
  input  logic [DATA_W-1:0]  LoadData,
  input  logic [1:0]         ReadAddr,
  output logic [DATA_W-1:0]  ReadData,
  output logic [1:0]         ALUOp,
  output logic [DATA_W-1:0]  ALUSrcA,
  output logic [DATA_W-1:0]  ALUSrcB,
  input  logic [DATA_W-1:0]  Result,
  output logic               ZeroFlag,
  output logic               Done
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic [DATA_W-1:0]  src_a_q, src_a_d;
  logic [DATA_W-1:0]  src_b_q, src_b_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               zero_q, zero_d;

  instr_t            dec;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic              rf_load_en, rf_wb_en;

  assign dec        = decode(instr_q);
  assign rf_load_en = (state_q == IDLE) && LoadEn;
  assign rf_wb_en   = (state_q == WB);

  seq_regfile u_rf (
    .clk       (CLK),
    .rst       (Reset),
    .load_en   (rf_load_en),
    .load_addr (LoadAddr),
    .load_data (LoadData),
    .wb_en     (rf_wb_en),
    .wb_addr   (dec.rd),
    .wb_data   (result_q),
    .rd_a_addr (dec.rd),
    .rd_b_addr (dec.rs),
    .rd_c_addr (ReadAddr),
    .rd_a_data (rf_a),
    .rd_b_data (rf_b),
    .rd_c_data (ReadData)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_op_d = alu_op_q;
    src_a_d  = src_a_q;
    src_b_d  = src_b_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        // a preload in the same cycle wins over instruction acceptance
        if (InstrValid && !LoadEn) begin
          instr_d = Instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_op_d = dec.op;
        src_a_d  = rf_a;
        src_b_d  = dec.imm ? {4'b0000, dec.imm4} : rf_b;
        state_d  = EXEC;
      end
      EXEC: begin
        result_d = Result;
        state_d  = WB;
      end
      WB: begin
        zero_d  = (result_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      instr_q  <= '0;
      alu_op_q <= '0;
      src_a_q  <= '0;
      src_b_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_op_q <= alu_op_d;
      src_a_q  <= src_a_d;
      src_b_q  <= src_b_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign InstrReady = (state_q == IDLE) && !LoadEn;
  // a reset landing on WB aborts the write-back, so suppress the pulse too
  assign Done       = (state_q == WB) && !Reset;
  assign ALUOp      = alu_op_q;
  assign ALUSrcA    = src_a_q;
  assign ALUSrcB    = src_b_q;
  assign ZeroFlag   = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed and random checks of alu_sequencer against an architectural model
// (register array plus zero flag) with a behavioural ALU closing the loop.
module tb_alu_sequencer;

  logic       CLK = 1'b0;
  logic       Reset, InstrValid, LoadEn;
  logic [8:0] Instr;
  logic [1:0] LoadAddr, ReadAddr, ALUOp;
  logic [7:0] LoadData, ReadData, ALUSrcA, ALUSrcB, Result;
  logic       InstrReady, ZeroFlag, Done;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_reg [4];

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) & int'(b);
      2'd1:    r = int'(a) + int'(b);
      2'd2:    r = int'(a) ^ int'(b);
      default: r = int'(a) - int'(b) + 256;
    endcase
    r = r % 256;
    return 8'(r);
  endfunction

  always_comb Result = alu_f(ALUOp, ALUSrcA, ALUSrcB);

  alu_sequencer dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrReady (InstrReady),
    .LoadEn     (LoadEn),
    .LoadAddr   (LoadAddr),
    .LoadData   (LoadData),
    .ReadAddr   (ReadAddr),
    .ReadData   (ReadData),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .Result     (Result),
    .ZeroFlag   (ZeroFlag),
    .Done       (Done)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 4; i++) begin
      tick();
      ReadAddr = 2'(i);
      #1 check(tag, ReadData, m_reg[i]);
    end
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    tick();
    LoadEn = 1'b0;
    m_reg[a] = d;
    ReadAddr = a;
    #1 check("load_read", ReadData, d);
  endtask

  // Issues one instruction from IDLE and follows it through write-back.
  task automatic run_instr(input logic [8:0] ins, input bit ld_dec);
    logic [1:0] op, rd, rs;
    logic [7:0] a, b, res;
    op  = ins[7:6];
    rd  = ins[5:4];
    rs  = ins[3:2];
    a   = m_reg[rd];
    b   = ins[8] ? {4'b0000, ins[3:0]} : m_reg[rs];
    res = alu_f(op, a, b);
    InstrValid = 1'b1; Instr = ins;
    check("ready_idle", InstrReady, 1);
    check("done_idle", Done, 0);
    tick();
    InstrValid = 1'($urandom); Instr = 9'($urandom);
    if (ld_dec) begin
      LoadEn = 1'b1; LoadAddr = rd; LoadData = ~a;
    end
    #1 check("ready_decode", InstrReady, 0);
    check("done_decode", Done, 0);
    tick();
    LoadEn = 1'b0; InstrValid = 1'b0;
    check("aluop_exec", ALUOp, op);
    check("srca_exec", ALUSrcA, a);
    check("srcb_exec", ALUSrcB, b);
    check("done_exec", Done, 0);
    tick();
    check("done_wb", Done, 1);
    check("ready_wb", InstrReady, 0);
    tick();
    m_reg[rd] = res;
    ReadAddr = rd;
    #1 check("wb_value", ReadData, res);
    check("zero_flag", ZeroFlag, (res == 8'h00) ? 8'd1 : 8'd0);
    check("done_after", Done, 0);
    check("ready_after", InstrReady, 1);
    check("aluop_hold", ALUOp, op);
  endtask

  initial begin
    Reset = 1'b1; InstrValid = 1'b0; LoadEn = 1'b0; Instr = '0;
    LoadAddr = '0; LoadData = '0; ReadAddr = '0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    tick(); tick();
    Reset = 1'b0;
    #1 check("rst_done", Done, 0);
    check("rst_zero", ZeroFlag, 0);
    check("rst_ready", InstrReady, 1);
    check("rst_aluop", ALUOp, 0);
    check("rst_srca", ALUSrcA, 0);
    check("rst_srcb", ALUSrcB, 0);
    sweep("rst_regs");

    // ADD R0,R1
    load(2'd0, 8'h0F);
    load(2'd1, 8'hF0);
    run_instr(9'b0_01_00_01_00, 1'b0);

    // SUB R2,#5 -> zero
    load(2'd2, 8'h05);
    run_instr(9'b1_11_10_0101, 1'b0);

    // SUB R3,#1 wraps
    load(2'd3, 8'h00);
    run_instr(9'b1_11_11_0001, 1'b0);

    // XOR R1,R1 reads the pre-instruction value twice
    load(2'd1, 8'hA5);
    run_instr(9'b0_10_01_01_00, 1'b0);

    // Load and instruction offered together: the load wins
    tick();
    LoadEn = 1'b1; LoadAddr = 2'd2; LoadData = 8'h33;
    InstrValid = 1'b1; Instr = 9'b0_01_10_11_00;
    #1 check("both_ready", InstrReady, 0);
    tick();
    LoadEn = 1'b0;
    m_reg[2] = 8'h33;
    ReadAddr = 2'd2;
    #1 check("both_load", ReadData, 8'h33);
    check("both_not_taken", InstrReady, 1);
    run_instr(9'b0_01_10_11_00, 1'b0);

    // LoadEn during DECODE is ignored
    run_instr(9'b0_00_00_01_00, 1'b1);
    sweep("dec_load_ign");

    // Reset while ADD R0,R1 is in EXEC
    tick();
    InstrValid = 1'b1; Instr = 9'b0_01_00_01_00;
    tick();
    InstrValid = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    #1 check("abort_done", Done, 0);
    check("abort_ready", InstrReady, 1);
    check("abort_zero", ZeroFlag, 0);
    check("abort_aluop", ALUOp, 0);
    check("abort_srca", ALUSrcA, 0);
    check("abort_srcb", ALUSrcB, 0);
    tick();
    check("abort_done2", Done, 0);
    sweep("abort_regs");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) load(2'($urandom), 8'($urandom));
      run_instr(9'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    sweep("final_regs");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
